// File: rtl/exe_muldiv_pkg.sv
// exe_muldiv_pkg: opcodes, FSM states and operand-signedness helpers for the RV32M unit
package exe_muldiv_pkg;
  localparam int MD_ITER = 32;
  localparam logic [6:0] MD_FUNCT7 = 7'b0000001;
  typedef enum logic [2:0] {
    MD_OP_MUL, MD_OP_MULH, MD_OP_MULHSU, MD_OP_MULHU,
    MD_OP_DIV, MD_OP_DIVU, MD_OP_REM, MD_OP_REMU
  } md_op_e;
  typedef enum logic [1:0] {MD_ST_IDLE, MD_ST_CALC, MD_ST_FIX, MD_ST_DONE} md_state_e;
  function automatic logic is_div(md_op_e op);
    return op inside {MD_OP_DIV, MD_OP_DIVU, MD_OP_REM, MD_OP_REMU};
  endfunction
  function automatic logic is_rem(md_op_e op);
    return op inside {MD_OP_REM, MD_OP_REMU};
  endfunction
  function automatic logic rs1_signed(md_op_e op);
    return op inside {MD_OP_MULH, MD_OP_MULHSU, MD_OP_DIV, MD_OP_REM};
  endfunction
  function automatic logic rs2_signed(md_op_e op);
    return op inside {MD_OP_MULH, MD_OP_DIV, MD_OP_REM};
  endfunction
endpackage

// File: rtl/exe_muldiv_if.sv
// exe_muldiv_if: request/response bundle between the EXE stage and the mul/div unit
interface exe_muldiv_if;
  logic        flush;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [4:0]  req_rd_idx;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        stall;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd_idx;
  modport master (
    output flush, req_valid, req_op, req_rd_idx, rs1_data, rs2_data,
    input  stall, busy, resp_valid, resp_data, resp_rd_idx
  );
  modport slave (
    input  flush, req_valid, req_op, req_rd_idx, rs1_data, rs2_data,
    output stall, busy, resp_valid, resp_data, resp_rd_idx
  );
endinterface

// File: rtl/exe_muldiv_md_addsub.sv
// md_addsub: 33-bit add/subtract with carry-out, shared by multiply accumulate and divide trial
module md_addsub (
  input  logic [32:0] a,
  input  logic [32:0] b,
  input  logic        sub,
  output logic [32:0] sum,
  output logic        cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, sub ? ~b : b} + 34'(sub);
endmodule

// File: rtl/exe_muldiv.sv
// exe_muldiv: iterative RV32M multiply/divide unit that stalls the front of the pipeline while busy
module exe_muldiv
  import exe_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic clk,
  input logic rstn,
  exe_muldiv_if.slave md
);
  md_state_e state, state_nx;
  md_op_e op, op_in;
  logic [4:0] cnt, rd_idx, resp_rd_q;
  logic [2*XLEN-1:0] acc, acc_nx, prod;
  logic [XLEN-1:0] opb, a_mag, b_mag, spec_res, div_sel, div_res, res, resp_data_q;
  logic neg, neg_a, neg_b, accept, special;
  logic [XLEN:0] add_a, add_b, add_sum;
  logic add_cout;
  assign op_in = md_op_e'(md.req_op);
  assign accept = state == MD_ST_IDLE && md.req_valid && !md.flush;
  assign neg_a = rs1_signed(op_in) && md.rs1_data[XLEN-1];
  assign neg_b = rs2_signed(op_in) && md.rs2_data[XLEN-1];
  assign a_mag = neg_a ? -md.rs1_data : md.rs1_data;
  assign b_mag = neg_b ? -md.rs2_data : md.rs2_data;
  assign special = is_div(op_in) && (md.rs2_data == '0 ||
    (rs2_signed(op_in) && md.rs1_data == {1'b1, {(XLEN-1){1'b0}}} && md.rs2_data == '1));
  assign spec_res = md.rs2_data == '0 ? (is_rem(op_in) ? md.rs1_data : '1)
                                      : (is_rem(op_in) ? '0 : {1'b1, {(XLEN-1){1'b0}}});
  // Divide feeds the shifted remainder {rem, next dividend bit}; multiply adds the multiplicand when the multiplier LSB is set
  assign add_a = is_div(op) ? acc[2*XLEN-1:XLEN-1] : {1'b0, acc[2*XLEN-1:XLEN]};
  assign add_b = {1'b0, (is_div(op) || acc[0]) ? opb : {XLEN{1'b0}}};
  md_addsub u_addsub (.a(add_a), .b(add_b), .sub(is_div(op)), .sum(add_sum), .cout(add_cout));
  assign acc_nx = is_div(op)
    ? {add_cout ? add_sum[XLEN-1:0] : acc[2*XLEN-2:XLEN-1], acc[XLEN-2:0], add_cout}
    : {add_sum, acc[XLEN-1:1]};
  assign prod = neg ? -acc : acc;
  assign div_sel = is_rem(op) ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
  assign div_res = neg ? -div_sel : div_sel;
  assign res = is_div(op) ? div_res : (op == MD_OP_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  always_comb begin
    state_nx = state;
    state_nx = (state != MD_ST_IDLE && md.flush) ? MD_ST_IDLE :
               state == MD_ST_IDLE ? (accept ? (special ? MD_ST_DONE : MD_ST_CALC) : MD_ST_IDLE) :
               state == MD_ST_CALC ? (cnt == 5'(MD_ITER - 1) ? MD_ST_FIX : MD_ST_CALC) :
               state == MD_ST_FIX  ? MD_ST_DONE : MD_ST_IDLE;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= MD_ST_IDLE;
      op <= MD_OP_MUL;
      cnt <= '0;
      rd_idx <= '0;
      acc <= '0;
      opb <= '0;
      neg <= 1'b0;
      resp_data_q <= '0;
      resp_rd_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op <= op_in;
        rd_idx <= md.req_rd_idx;
        neg <= is_rem(op_in) ? neg_a : neg_a ^ neg_b;
        cnt <= '0;
        acc <= {{XLEN{1'b0}}, is_div(op_in) ? a_mag : b_mag};
        opb <= is_div(op_in) ? b_mag : a_mag;
      end
      if (state == MD_ST_CALC) begin
        cnt <= cnt + 5'd1;
        acc <= acc_nx;
      end
      if (accept && special) begin
        resp_data_q <= spec_res;
        resp_rd_q <= md.req_rd_idx;
      end
      if (state == MD_ST_FIX && !md.flush) begin
        resp_data_q <= res;
        resp_rd_q <= rd_idx;
      end
    end
  end
  assign md.stall = accept || state == MD_ST_CALC || state == MD_ST_FIX;
  assign md.busy = state != MD_ST_IDLE;
  assign md.resp_valid = state == MD_ST_DONE;
  assign md.resp_data = resp_data_q;
  assign md.resp_rd_idx = resp_rd_q;
endmodule

// File: tb/tb_exe_muldiv.sv
// tb_exe_muldiv: directed and randomized checks of exe_muldiv against an arithmetic reference model
module tb_exe_muldiv;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int checks = 0;
  int failures = 0;
  exe_muldiv_if mif();
  exe_muldiv dut (.clk(clk), .rstn(rstn), .md(mif));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    logic [63:0] pu = {32'b0, a} * {32'b0, b};
    logic [63:0] p;
    int qa = $signed(a);
    int qb = $signed(b);
    case (op)
      3'd0: return pu[31:0];
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: return pu[63:32];
      default: begin
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
        case (op)
          3'd4: return 32'(qa / qb);
          3'd5: return a / b;
          3'd6: return 32'(qa % qb);
          default: return a % b;
        endcase
      end
    endcase
    return ua[31:0];
  endfunction

  function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input logic [4:0] rd, input int lat);
    int n = 0;
    logic stall_ok = 1'b1;
    @(negedge clk);
    mif.req_valid = 1'b1;
    mif.req_op = op;
    mif.req_rd_idx = rd;
    mif.rs1_data = a;
    mif.rs2_data = b;
    #1 chk({tag, " stall@T"}, 32'(mif.stall), 32'd1);
    do begin
      @(negedge clk);
      n++;
      if (!mif.resp_valid && !mif.stall) stall_ok = 1'b0;
    end while (!mif.resp_valid && n < 60);
    chk({tag, " latency"}, 32'(n), 32'(lat));
    chk({tag, " stall_busy"}, 32'(stall_ok), 32'd1);
    chk({tag, " stall_done"}, 32'(mif.stall), 32'd0);
    chk({tag, " data"}, mif.resp_data, exp);
    chk({tag, " rd"}, 32'(mif.resp_rd_idx), 32'(rd));
    mif.req_valid = 1'b0;
    @(negedge clk);
    chk({tag, " idle_after"}, {30'b0, mif.busy, mif.resp_valid}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw;
    logic [2:0] op;
    logic [31:0] a, b;
    mif.flush = 1'b0;
    mif.req_valid = 1'b0;
    mif.req_op = '0;
    mif.req_rd_idx = '0;
    mif.rs1_data = '0;
    mif.rs2_data = '0;
    #2;
    chk("reset outs", {mif.busy, mif.resp_valid, mif.stall, mif.resp_rd_idx}, 32'd0);
    chk("reset data", mif.resp_data, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    do_op("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 5'd1, 34);
    do_op("MULH min*min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 5'd2, 34);
    do_op("MULHU max*max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd3, 34);
    do_op("MULHSU -1*2", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 5'd4, 34);
    do_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 5'd5, 34);
    do_op("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 5'd6, 34);
    do_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 32'd14, 5'd7, 34);
    do_op("REMU 100/7", 3'd7, 32'd100, 32'd7, 32'd2, 5'd8, 34);
    do_op("DIVU 5/0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 5'd9, 1);
    do_op("REM 5/0", 3'd6, 32'd5, 32'd0, 32'd5, 5'd10, 1);
    do_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 5'd11, 1);
    do_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 5'd12, 1);
    @(negedge clk);
    mif.req_valid = 1'b1;
    mif.flush = 1'b1;
    mif.req_op = 3'd4;
    #1 chk("idle flush stall", 32'(mif.stall), 32'd0);
    @(negedge clk);
    chk("idle flush busy", 32'(mif.busy), 32'd0);
    mif.flush = 1'b0;
    mif.req_valid = 1'b0;
    @(negedge clk);
    mif.req_valid = 1'b1;
    mif.req_op = 3'd4;
    mif.req_rd_idx = 5'd13;
    mif.rs1_data = 32'd100;
    mif.rs2_data = 32'd7;
    repeat (10) @(negedge clk);
    mif.flush = 1'b1;
    mif.req_valid = 1'b0;
    @(negedge clk);
    chk("flush busy", 32'(mif.busy), 32'd0);
    mif.flush = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      saw |= mif.resp_valid;
    end
    chk("flush no resp", 32'(saw), 32'd0);
    do_op("MUL 3*4", 3'd0, 32'd3, 32'd4, 32'd12, 5'd14, 34);
    @(negedge clk);
    mif.req_valid = 1'b1;
    mif.req_op = 3'd0;
    mif.req_rd_idx = 5'd15;
    mif.rs1_data = 32'h1234_5;
    mif.rs2_data = 32'h777;
    repeat (20) @(negedge clk);
    rstn = 1'b0;
    mif.req_valid = 1'b0;
    #1;
    chk("rst busy/valid/rd", {mif.busy, mif.resp_valid, mif.resp_rd_idx}, 32'd0);
    chk("rst data", mif.resp_data, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    do_op("MUL post-rst", 3'd0, 32'h1234_5, 32'h777, model(3'd0, 32'h1234_5, 32'h777), 5'd16, 34);
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      do_op($sformatf("rand%0d op%0d %h,%h", i, op, a, b), op, a, b, model(op, a, b),
            5'($urandom_range(0, 31)), lat_of(op, a, b));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/exe_muldiv.md
Name: exe_muldiv

Overview:
- Iterative RV32M multiply/divide unit inside the EXE stage. It consumes the operand and decode fields registered by the ID/EXE pipeline register.
- It runs a 32-iteration shift-add or restoring-division loop and holds the front of the pipeline with `stall` while busy.
- The result goes to the EXE result mux and then to EXE/MEM.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported; the iteration count equals XLEN.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- flush  in  1  branch or load-use flush (b_flush|lu_flush); kills any operation in flight
- req_valid  in  1  EXE instruction is an M-extension op (exe_alu & funct7==7'b0000001)
- req_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- req_rd_idx  in  5  destination register
- rs1_data  in  32  operand A (exe_rs1_data, post-forwarding)
- rs2_data  in  32  operand B (exe_rs2_data, post-forwarding)
- stall  out  1  hold PC, IF/ID and ID/EXE
- busy  out  1  FSM not in IDLE
- resp_valid  out  1  result valid, one-cycle pulse
- resp_data  out  32  result
- resp_rd_idx  out  5  destination of the result

Behaviour:
- Reset values: state=IDLE, busy=0, resp_valid=0, resp_data=0, resp_rd_idx=0, all internal registers 0.
- States:
  - IDLE: waiting for a request.
  - CALC: 32 iterations, counter cnt 0..31.
  - FIX: sign correction and result select.
  - DONE: resp_valid=1 for this single cycle.
- IDLE & req_valid & ~flush, cycle T:
  - Latch op, rd_idx, operand magnitudes, sign flags.
  - Special case → DONE at T+1.
  - Otherwise → CALC.
- CALC → FIX after cnt==31. FIX → DONE. DONE → IDLE unconditionally; req_valid is ignored in DONE.
- Latency:
  - Normal: resp_valid in cycle T+34, with CALC at T+1..T+32 and FIX at T+33.
  - Special case: resp_valid in cycle T+1.
- stall (combinational) = (IDLE & req_valid & ~flush) | CALC | FIX.
- stall=0 in DONE, so the pipeline advances on the DONE edge. The next instruction is therefore seen only in IDLE; there is no double-accept.
- Signedness:
  - rs1 is signed for MULH, MULHSU, DIV, REM.
  - rs2 is signed for MULH, DIV, REM.
  - MUL takes the low word and is sign-agnostic.
  - Magnitudes are the two's complement of negative signed operands. 0x80000000 has magnitude 0x80000000 (unsigned 32-bit).
- Multiply:
  - 64-bit accumulator, shift-add, LSB-first over the multiplier.
  - FIX negates the 64-bit product iff the operand signs differ (signed ops only).
  - MUL returns [31:0]; MULH/MULHSU/MULHU return [63:32].
- Divide:
  - Restoring algorithm, 33-bit partial remainder, one quotient bit per cycle, MSB first.
  - FIX negates the quotient iff the signs differ (DIV), and negates the remainder iff the dividend is negative (REM).
- Special cases:
  - Divide by zero: quotient 0xFFFFFFFF (DIV/DIVU); remainder = rs1 (REM/REMU).
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, DIV/REM): quotient 0x80000000, remainder 0.
- flush:
  - Any state except IDLE → IDLE at the next edge; no resp_valid.
  - Flush in IDLE blocks acceptance that cycle.
  - Flush coinciding with DONE still shows resp_valid=1 that cycle. The consumer register discards it; the FSM returns to IDLE as normal.
- Reset mid-operation: asynchronous return to reset values; nothing is resumed.
- resp_data and resp_rd_idx hold their last values outside DONE. Only resp_valid qualifies them.

Decomposition:
- define.v gains:
  - `MD_OP_*` funct3 encodings
  - `MD_FUNCT7` (7'b0000001)
  - `MD_ST_IDLE/CALC/FIX/DONE` 2-bit state encodings
  - `MD_ITER` (32)
- One natural sub-module: md_addsub, a 33-bit add/subtract with carry-out. It is shared by the multiply accumulate and the divide trial-subtract, so only one adder is instantiated.
- FSM, counter and sign logic stay in exe_muldiv.

Test Plan:
- MUL 7×(-3) (rs1=7, rs2=0xFFFFFFFD) → resp_valid at T+34, resp_data=0xFFFFFFEB; stall high T..T+33 and low at T+34.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 5, each with resp_valid at T+1; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM of the same → 0.
- Accept DIV, assert flush at T+10 → busy=0 at T+11, no resp_valid ever. A back-to-back MUL 3×4 presented next → 12 after 34 cycles.
- Deassert rstn at T+20 of a MUL → busy, resp_valid, resp_data=0 immediately. After release, a fresh request completes correctly.
